tdm_serial_audio_encoder: RTL and testbench

TDM_SERIAL_AUDIO_ENCODER -- requirements
Module: tdm_serial_audio_encoder

---
 rtl/serial_audio_pkg.sv | 19 +
 rtl/sample_holding_register.sv | 44 ++++
 rtl/tdm_serial_audio_encoder.sv | 190 +++++++++++++++++++
 tb/tb_tdm_serial_audio_encoder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_audio_pkg.sv
// Shared definitions for the serial audio encoders: format codes, FSM state
// type and a helper that folds the reserved format code onto left-justified.
package serial_audio_pkg;

  localparam logic [1:0] FMT_I2S = 2'd0;
  localparam logic [1:0] FMT_LJ  = 2'd1;
  localparam logic [1:0] FMT_RJ  = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } enc_state_t;

  // Code 3 is reserved and is treated exactly like left-justified.
  function automatic logic [1:0] fmt_normalise(input logic [1:0] code);
    return (code == FMT_I2S || code == FMT_RJ) ? code : FMT_LJ;
  endfunction

endpackage

// File: rtl/sample_holding_register.sv
// Single-entry sample buffer between the upstream valid/ready producer and the
// slot shifter. The consumer empties it with a one-cycle take pulse; a new
// sample is only accepted while empty, so take and write never coincide.
module sample_holding_register #(
  parameter int data_width    = 16,
  parameter int channel_width = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [data_width-1:0]    wr_data,
  input  logic [channel_width-1:0] wr_channel,
  input  logic                     rd_take,
  output logic                     full,
  output logic [data_width-1:0]    data,
  output logic [channel_width-1:0] channel
);

  logic                     full_reg;
  logic [data_width-1:0]    data_reg;
  logic [channel_width-1:0] channel_reg;

  assign wr_ready = ~full_reg;
  assign full     = full_reg;
  assign data     = data_reg;
  assign channel  = channel_reg;

  // Capture a sample when empty; drop the occupied flag when the consumer takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_reg    <= 1'b0;
      data_reg    <= '0;
      channel_reg <= '0;
    end else if (rd_take) begin
      full_reg <= 1'b0;
    end else if (wr_valid && !full_reg) begin
      full_reg    <= 1'b1;
      data_reg    <= wr_data;
      channel_reg <= wr_channel;
    end
  end

endmodule

// File: rtl/tdm_serial_audio_encoder.sv
// TDM serial audio encoder: serialises one buffered sample per channel slot,
// MSB first, in I2S, left-justified or right-justified placement, and drives a
// frame-sync level that is low for the first half of the slots.
module tdm_serial_audio_encoder
  import serial_audio_pkg::*;
#(
  parameter int audio_width = 16,
  parameter int slot_width  = 32,
  parameter int channels    = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [1:0]                  format,
  input  logic                        fsync_polarity,
  input  logic                        i_valid,
  output logic                        i_ready,
  input  logic [$clog2(channels)-1:0] i_channel,
  input  logic [audio_width-1:0]      i_audio,
  output logic                        is_underrun,
  output logic                        sclk,
  output logic                        fsync,
  output logic                        sdo
);

  localparam int ch_w     = $clog2(channels);
  localparam int bit_w    = $clog2(slot_width);
  localparam int lj_shift = slot_width - audio_width;
  localparam logic [bit_w-1:0] last_bit = bit_w'(slot_width - 1);
  localparam logic [ch_w-1:0]  last_ch  = ch_w'(channels - 1);
  localparam logic [ch_w-1:0]  half_ch  = ch_w'(channels / 2);

  generate
    if (audio_width < 2) begin : g_bad_audio
      $error("tdm_serial_audio_encoder: audio_width must be at least 2");
    end
    if (slot_width < audio_width) begin : g_bad_slot
      $error("tdm_serial_audio_encoder: slot_width must be >= audio_width");
    end
    if ((channels % 2) != 0 || channels < 2 || channels > 16) begin : g_bad_channels
      $error("tdm_serial_audio_encoder: channels must be even and within 2..16");
    end
  endgenerate

  enc_state_t             state_reg, state_next;
  logic [bit_w-1:0]       bit_reg, bit_next;
  logic [ch_w-1:0]        ch_reg, ch_next;
  logic [slot_width-1:0]  shifter_reg, shifter_next;
  logic [1:0]             fmt_reg, fmt_next;
  logic                   sdo_reg, sdo_next;
  logic                   dly_reg, dly_next;
  logic                   raw_reg, raw_next;
  logic                   underrun_reg, underrun_next;

  logic                   buf_full;
  logic                   buf_take;
  logic [audio_width-1:0] buf_data;
  logic [ch_w-1:0]        buf_channel;

  logic                   do_load;
  logic                   do_shift;
  logic [ch_w-1:0]        load_ch;
  logic [ch_w-1:0]        ch_follow;
  logic [slot_width-1:0]  sample_ext;

  sample_holding_register #(
    .data_width   (audio_width),
    .channel_width(ch_w)
  ) u_holding (
    .clk       (clk),
    .reset     (reset),
    .wr_valid  (i_valid),
    .wr_ready  (i_ready),
    .wr_data   (i_audio),
    .wr_channel(i_channel),
    .rd_take   (buf_take),
    .full      (buf_full),
    .data      (buf_data),
    .channel   (buf_channel)
  );

  assign ch_follow  = (ch_reg == last_ch) ? '0 : ch_reg + 1'b1;
  assign sample_ext = slot_width'(buf_data);

  assign sclk        = ~clk;
  assign fsync       = raw_reg ^ fsync_polarity;
  assign sdo         = sdo_reg;
  assign is_underrun = underrun_reg;

  // Register all encoder state; reset aborts any frame in progress at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      bit_reg      <= '0;
      ch_reg       <= '0;
      shifter_reg  <= '0;
      fmt_reg      <= FMT_I2S;
      sdo_reg      <= 1'b0;
      dly_reg      <= 1'b0;
      raw_reg      <= 1'b1;
      underrun_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_reg      <= bit_next;
      ch_reg       <= ch_next;
      shifter_reg  <= shifter_next;
      fmt_reg      <= fmt_next;
      sdo_reg      <= sdo_next;
      dly_reg      <= dly_next;
      raw_reg      <= raw_next;
      underrun_reg <= underrun_next;
    end
  end

  // Decide load / shift / stop for this edge, then derive every next value from that.
  always_comb begin
    state_next    = state_reg;
    bit_next      = bit_reg;
    ch_next       = ch_reg;
    shifter_next  = shifter_reg;
    fmt_next      = fmt_reg;
    sdo_next      = sdo_reg;
    dly_next      = dly_reg;
    raw_next      = raw_reg;
    underrun_next = underrun_reg;
    buf_take      = 1'b0;
    do_load       = 1'b0;
    do_shift      = 1'b0;
    load_ch       = '0;

    case (state_reg)
      ST_IDLE: begin
        // Only a channel-0 sample can open a frame; anything else is dropped.
        if (buf_full) begin
          buf_take = 1'b1;
          if (buf_channel == '0) begin
            do_load = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (bit_reg != last_bit) begin
          do_shift = 1'b1;
        end else if (buf_full && buf_channel == ch_follow) begin
          buf_take = 1'b1;
          do_load  = 1'b1;
          load_ch  = ch_follow;
        end else begin
          // Missing or out-of-order sample: flush it and fall back to idle.
          buf_take = buf_full;
        end
      end
      default: ;
    endcase

    if (do_load) begin
      // Format is only sampled at the start of a frame.
      if (load_ch == '0) begin
        fmt_next = fmt_normalise(format);
      end
      shifter_next  = (fmt_next == FMT_RJ) ? sample_ext : (sample_ext << lj_shift);
      state_next    = ST_RUN;
      bit_next      = '0;
      ch_next       = load_ch;
      raw_next      = (load_ch >= half_ch);
      underrun_next = 1'b0;
    end else if (do_shift) begin
      shifter_next = shifter_reg << 1;
      bit_next     = bit_reg + 1'b1;
    end else begin
      state_next   = ST_IDLE;
      bit_next     = '0;
      ch_next      = '0;
      shifter_next = '0;
      raw_next     = 1'b1;
      if (state_reg == ST_RUN) begin
        underrun_next = 1'b1;
      end
    end

    // I2S emits the bit that was at the shifter MSB one clock earlier.
    if (do_load || do_shift) begin
      dly_next = shifter_next[slot_width-1];
      sdo_next = (fmt_next == FMT_I2S) ? dly_reg : shifter_next[slot_width-1];
    end else begin
      dly_next = 1'b0;
      sdo_next = 1'b0;
    end
  end

endmodule

// File: tb/tb_tdm_serial_audio_encoder.sv
// Bench for tdm_serial_audio_encoder: a 2-channel and an 8-channel instance
// share stimulus; expected outputs come from a stream-level model that places
// each sample bit at its position in the frame timeline.
module tb_tdm_serial_audio_encoder;

  localparam int AW = 16;
  localparam int SW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    format;
  logic          fsync_polarity;
  logic [AW-1:0] i_audio;
  logic [2:0]    ch_drive;
  logic          valid2, valid8;
  logic          ready2, ready8, und2, und8, sclk2, sclk8, fs2, fs8, sdo2, sdo8;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;

  logic [AW-1:0] smp [0:15];
  bit            und_prev [0:1];

  always #5 clk = ~clk;

  tdm_serial_audio_encoder #(.audio_width(AW), .slot_width(SW), .channels(2)) dut2 (
    .clk(clk), .reset(reset), .format(format), .fsync_polarity(fsync_polarity),
    .i_valid(valid2), .i_ready(ready2), .i_channel(ch_drive[0:0]), .i_audio(i_audio),
    .is_underrun(und2), .sclk(sclk2), .fsync(fs2), .sdo(sdo2));

  tdm_serial_audio_encoder #(.audio_width(AW), .slot_width(SW), .channels(8)) dut8 (
    .clk(clk), .reset(reset), .format(format), .fsync_polarity(fsync_polarity),
    .i_valid(valid8), .i_ready(ready8), .i_channel(ch_drive), .i_audio(i_audio),
    .is_underrun(und8), .sclk(sclk8), .fsync(fs8), .sdo(sdo8));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [1:0] norm_fmt(input logic [1:0] f);
    return (f == 2'd3) ? 2'd1 : f;
  endfunction

  // Bit b (0 = first bit of the slot) of a sample placed in a slot.
  function automatic logic slot_bit(input logic [AW-1:0] s, input int b, input logic [1:0] f);
    if (f == 2'd2) begin
      if (b >= SW - AW) return s[SW-1-b];
      return 1'b0;
    end
    if (b < AW) return s[AW-1-b];
    return 1'b0;
  endfunction

  task automatic check_reset(input int sel);
    check("rst_sdo",   sel ? sdo8 : sdo2, 0);
    check("rst_fsync", sel ? fs8 : fs2, 32'(!fsync_polarity));
    check("rst_ready", sel ? ready8 : ready2, 1);
    check("rst_under", sel ? und8 : und2, 0);
  endtask

  // Offer a channel-1 sample to an idle encoder: taken, dropped, no output.
  task automatic idle_offer(input int sel);
    i_audio  = 16'($urandom);
    ch_drive = 3'd1;
    valid2   = (sel == 0);
    valid8   = (sel != 0);
    @(posedge clk);
    @(negedge clk);
    valid2 = 1'b0;
    valid8 = 1'b0;
    check("idle_ready_low", sel ? ready8 : ready2, 0);
    check("idle_sdo0",      sel ? sdo8 : sdo2, 0);
    check("idle_under0",    sel ? und8 : und2, 32'(und_prev[sel]));
    @(posedge clk);
    @(negedge clk);
    check("idle_ready_high", sel ? ready8 : ready2, 1);
    check("idle_sdo1",       sel ? sdo8 : sdo2, 0);
    check("idle_fsync",      sel ? fs8 : fs2, 32'(!fsync_polarity));
    check("idle_under1",     sel ? und8 : und2, 32'(und_prev[sel]));
  endtask

  // Feed smp[0..n-1] as channels 0,1,2,... and check every cycle. Must be
  // called at a falling edge with the encoder idle and its buffer empty.
  task automatic run_stream(input int sel, input int n, input bit wobble,
                            input logic [1:0] fmt0, input bit pol, input int stop_t);
    int   nch, end_t, last_t, next_k, k;
    bit   mfull, drove;
    logic [1:0] fat  [0:600];
    logic [1:0] sfmt [0:15];
    logic       pbit [0:600];
    logic       e_sdo, e_raw, e_und;
    nch    = (sel != 0) ? 8 : 2;
    end_t  = 2 + SW * n;
    last_t = (stop_t > 0) ? stop_t : end_t + 3;
    for (int t = 0; t <= 600; t++) fat[t] = wobble ? 2'($urandom_range(0, 3)) : fmt0;
    for (int s = 0; s < n; s++) begin
      if (s % nch == 0) sfmt[s] = norm_fmt(fat[2 + SW * s]);
      else              sfmt[s] = sfmt[s-1];
    end
    pbit[0] = 1'b0;
    pbit[1] = 1'b0;
    for (int t = 2; t < end_t; t++) pbit[t] = slot_bit(smp[(t-2)/SW], (t-2) % SW, sfmt[(t-2)/SW]);
    fsync_polarity = pol;
    mfull  = 1'b0;
    next_k = 0;
    for (int t = 1; t <= last_t; t++) begin
      drove = !mfull && (next_k < n);
      if (drove) begin
        i_audio  = smp[next_k];
        ch_drive = 3'(next_k % nch);
        next_k++;
      end
      valid2 = drove && (sel == 0);
      valid8 = drove && (sel != 0);
      format = fat[t];
      @(posedge clk);
      if (t >= 2 && t < end_t && ((t - 2) % SW) == 0) mfull = 1'b0;
      else if (drove)                                   mfull = 1'b1;
      @(negedge clk);
      k = (t - 2) / SW;
      if (t < 2) begin
        e_sdo = 1'b0; e_raw = 1'b1; e_und = und_prev[sel];
      end else if (t < end_t) begin
        e_sdo = (sfmt[k] == 2'd0) ? pbit[t-1] : pbit[t];
        e_raw = ((k % nch) >= nch / 2);
        e_und = 1'b0;
      end else begin
        e_sdo = 1'b0; e_raw = 1'b1; e_und = 1'b1;
      end
      check($sformatf("sdo@%0d", t),   sel ? sdo8 : sdo2, 32'(e_sdo));
      check($sformatf("fsync@%0d", t), sel ? fs8 : fs2, 32'(e_raw ^ pol));
      check($sformatf("under@%0d", t), sel ? und8 : und2, 32'(e_und));
      check($sformatf("ready@%0d", t), sel ? ready8 : ready2, 32'(!mfull));
    end
    valid2 = 1'b0;
    valid8 = 1'b0;
    if (last_t >= end_t)  und_prev[sel] = 1'b1;
    else if (last_t >= 2) und_prev[sel] = 1'b0;
    $display("stream sel=%0d n=%0d fmt=%0d wobble=%0d pol=%0d cycles=%0d checks=%0d",
             sel, n, fmt0, wobble, pol, last_t, total_cnt);
  endtask

  initial begin
    int n;
    reset          = 1'b1;
    format         = 2'd0;
    fsync_polarity = 1'b0;
    valid2         = 1'b0;
    valid8         = 1'b0;
    i_audio        = '0;
    ch_drive       = '0;
    und_prev[0]    = 1'b0;
    und_prev[1]    = 1'b0;
    #1;
    check_reset(0);
    check_reset(1);
    check("sclk", sclk2, 32'(!clk));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Stray channel-1 sample before any frame: dropped, underrun stays 0.
    idle_offer(0);

    smp[0] = 16'hA5F0;
    smp[1] = 16'h0F0F;
    run_stream(0, 2, 1'b0, 2'd1, 1'b0, 0);  // left-justified
    run_stream(0, 2, 1'b0, 2'd0, 1'b0, 0);  // I2S
    run_stream(0, 2, 1'b0, 2'd0, 1'b1, 0);  // I2S, inverted fsync
    run_stream(0, 2, 1'b0, 2'd2, 1'b0, 0);  // right-justified
    run_stream(0, 1, 1'b0, 2'd3, 1'b0, 0);  // reserved code, channel 1 withheld

    // Stray channel-1 sample after an underrun: dropped, underrun stays 1.
    idle_offer(0);

    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(1, 6);
      for (int s = 0; s < n; s++) smp[s] = 16'($urandom);
      run_stream(0, n, 1'(r % 2), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0);
    end

    // Eight-channel frame: 256 clocks, fsync low for slots 0-3.
    for (int s = 0; s < 8; s++) smp[s] = 16'($urandom);
    run_stream(1, 8, 1'b0, 2'd1, 1'b0, 0);

    // Abort mid slot 5 with reset; outputs must return to reset values at once.
    for (int s = 0; s < 8; s++) smp[s] = 16'($urandom);
    run_stream(1, 8, 1'b1, 2'd1, 1'b1, 2 + SW * 5 + 9);
    reset = 1'b1;
    #1;
    check_reset(1);
    check_reset(0);
    und_prev[0] = 1'b0;
    und_prev[1] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("post_rst_sdo",   sdo8, 0);
      check("post_rst_fsync", fs8, 32'(!fsync_polarity));
      check("post_rst_ready", ready8, 1);
      check("post_rst_under", und8, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
